// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the multicycle CPU datapath
// and the word-addressed memory responder.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data/instruction memory answering CPU requests
// over req/ack after LATENCY wait cycles.
module mem_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            commit;

  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;

  logic            cur_we;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic            bad;
  logic [ADDR_WIDTH-1:0] idx;

  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem [2**ADDR_WIDTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the commit edge is the acceptance edge,
  // so the live bus values stand in for the latched ones.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_we    = bus.we;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end
    bad = (cur_addr[1:0] != 2'b00) ||
          (cur_addr[31:ADDR_WIDTH+2] != '0);
    idx = cur_addr[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && bus.req) begin
        lat_we    <= bus.we;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
      end
      if (commit) begin
        err_q <= bad;
        if (!bad && !cur_we)
          rdata_q <= mem[idx];
      end else if (state == RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  // Storage is never cleared; rst gates commits while held low.
  always_ff @(posedge clk) begin
    if (rst && commit && !bad && cur_we)
      mem[idx] <= cur_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.ack   = (state == RESP);
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder at
// LATENCY=2 and LATENCY=0.
module tb_mem_responder;

  localparam int AW = 7;
  localparam int L0 = 2;
  localparam int L1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mmem [2][128];
  logic [31:0] mrd  [2];

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout want ack", name);
  endfunction

  // Reference: an accepted request answers after lat cycles
  // with the result of the whole access.
  function automatic void accept(int d, logic we,
                                 logic [31:0] a,
                                 logic [31:0] wd);
    exp_t e;
    int   lat;
    lat   = (d == 0) ? L0 : L1;
    e.err = (a % 4 != 0) || (a / 4 >= 128);
    if (!e.err) begin
      if (we) mmem[d][a/4] = wd;
      else    mrd[d] = mmem[d][a/4];
    end
    e.rdata = mrd[d];
    e.cyc   = cyc + lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void mon(int d, logic err,
                              logic [31:0] rd);
    exp_t e;
    if ((d == 0 && q0.size() == 0) ||
        (d == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_ack%0d: got ack at %0d want none",
               d, cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("ack_cycle%0d", d), cyc, e.cyc);
    check($sformatf("err%0d", d), {31'b0, err}, {31'b0, e.err});
    check($sformatf("rdata%0d", d), rd, e.rdata);
  endfunction

  always @(negedge clk) if (rst && b0.ack) mon(0, b0.err, b0.rdata);
  always @(negedge clk) if (rst && b1.ack) mon(1, b1.err, b1.rdata);

  task automatic drive(int d, logic rq, logic we,
                       logic [31:0] a, logic [31:0] wd);
    if (d == 0) begin
      b0.req = rq; b0.we = we; b0.addr = a; b0.wdata = wd;
    end else begin
      b1.req = rq; b1.we = we; b1.addr = a; b1.wdata = wd;
    end
  endtask

  function automatic logic ack_of(int d);
    return (d == 0) ? b0.ack : b1.ack;
  endfunction

  function automatic logic busy_of(int d);
    return (d == 0) ? b0.busy : b1.busy;
  endfunction

  // Wait (bounded) until ack is seen at posedge+1; returns cycle.
  task automatic wait_ack(int d, output bit ok, output int at,
                          output int nb);
    ok = 0;
    at = 0;
    nb = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (busy_of(d)) nb++;
      if (ack_of(d)) begin
        ok = 1;
        at = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic txn(int d, logic we, logic [31:0] a,
                     logic [31:0] wd);
    bit ok;
    int at, nb, lat;
    lat = (d == 0) ? L0 : L1;
    drive(d, 1'b1, we, a, wd);
    @(posedge clk); #1;
    accept(d, we, a, wd);
    wait_ack(d, ok, at, nb);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!ok) flag($sformatf("txn_timeout%0d", d));
    else check($sformatf("busy_len%0d", d), nb, lat + 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(int d);
    if (d == 0) begin
      check("rst_ack0", {31'b0, b0.ack}, 32'h0);
      check("rst_err0", {31'b0, b0.err}, 32'h0);
      check("rst_busy0", {31'b0, b0.busy}, 32'h0);
      check("rst_rdata0", b0.rdata, 32'h0);
    end else begin
      check("rst_ack1", {31'b0, b1.ack}, 32'h0);
      check("rst_err1", {31'b0, b1.err}, 32'h0);
      check("rst_busy1", {31'b0, b1.busy}, 32'h0);
      check("rst_rdata1", b1.rdata, 32'h0);
    end
  endtask

  task automatic directed(int d);
    txn(d, 1, 32'h010, 32'h12345678);
    txn(d, 0, 32'h010, 32'h0);
    txn(d, 1, 32'h013, 32'hDEADBEEF);
    txn(d, 0, 32'h010, 32'h0);
    txn(d, 1, 32'h1FC, 32'h0BADF00D);
    txn(d, 0, 32'h010, 32'h0);
    txn(d, 0, 32'h200, 32'h0);
    txn(d, 0, 32'h1FC, 32'h0);
  endtask

  task automatic abort_test();
    txn(0, 1, 32'h020, 32'hAAAA5555);
    drive(0, 1'b1, 1'b1, 32'h020, 32'h0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    reset_checks(0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
    @(posedge clk); #3 rst = 1'b1;
    repeat (L0 + 3) @(posedge clk);
    #1;
    txn(0, 0, 32'h020, 32'h0);
  endtask

  task automatic b2b_test(int d);
    bit ok;
    int at1, at2, nb, lat;
    lat = (d == 0) ? L0 : L1;
    drive(d, 1'b1, 1'b1, 32'h030, 32'h11112222);
    @(posedge clk); #1;
    accept(d, 1, 32'h030, 32'h11112222);
    drive(d, 1'b1, 1'b1, 32'h030, 32'h33334444);
    wait_ack(d, ok, at1, nb);
    if (!ok) flag($sformatf("b2b_first%0d", d));
    drive(d, 1'b1, 1'b0, 32'h030, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    accept(d, 0, 32'h030, 32'h0);
    wait_ack(d, ok, at2, nb);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!ok) flag($sformatf("b2b_second%0d", d));
    else check($sformatf("b2b_spacing%0d", d),
               at2 - at1, lat + 2);
    @(posedge clk); #1;
  endtask

  task automatic random_test(int d);
    logic [31:0] a;
    int r;
    for (int i = 0; i < 16; i++)
      txn(d, 1, i * 4, $urandom);
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
      else if (r == 1)
        a = ($urandom | 32'h200) & 32'hFFFF_FFFC;
      else
        a = $urandom_range(0, 15) * 4;
      txn(d, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks(0);
    reset_checks(1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) directed(d);
    abort_test();
    for (int d = 0; d < 2; d++) b2b_test(d);
    for (int d = 0; d < 2; d++) random_test(d);
    repeat (4) @(posedge clk);
    #1;
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data/instruction memory that answers the multicycle CPU's memory requests over a req/ack handshake with configurable access latency.
- Sits between the datapath's memory address/write-data mux (IorD path) and a local storage array.
- Replaces the zero-latency combinational memory, so the controller FSM can stall in its fetch and memory-access states until ack.

Parameters:
- ADDR_WIDTH, 7, number of word-address bits; array holds 2^ADDR_WIDTH 32-bit words (default 128 words, byte range 0x000-0x1FF).
- LATENCY, 2, number of WAIT cycles between acceptance and response; 0 is legal.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  1  request valid, held by requester until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address; must be word aligned.
- wdata  in  32  write data; sampled with req.
- rdata  out  32  read data, registered; valid in the ack cycle of a read.
- ack  out  1  one-cycle response strobe.
- err  out  1  access error; meaningful only while ack=1.
- busy  out  1  1 while a transaction is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, ack=0, err=0, busy=0, rdata=0. The storage array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE: req is sampled only here.
  - If req=1 at an edge (acceptance edge E0): latch we, addr, wdata.
  - Go to WAIT with count=LATENCY-1 if LATENCY>0, else go directly to RESP.
- WAIT: count decrements each edge. When count=0 at an edge, go to RESP.
  - Input changes during WAIT are ignored; the latched values are used.
- Entering RESP (the edge that enters it), access is committed:
  - Error when latched addr[1:0] != 0, or latched addr[31:2] >= 2^ADDR_WIDTH.
  - Error access: no write; rdata unchanged; err register set to 1.
  - Valid write: mem[addr[ADDR_WIDTH+1:2]] <= wdata; rdata unchanged; err=0.
  - Valid read: rdata <= mem[addr[ADDR_WIDTH+1:2]]; err=0.
- RESP lasts exactly one cycle with ack=1. Next edge goes to IDLE; ack and err return to 0.
- Timing: ack is high during the cycle following edge E0+LATENCY+1 edges... more precisely:
  - LATENCY=0: ack high in the cycle right after E0.
  - LATENCY=L: ack high in the cycle after edge E(L).
  - Minimum spacing between acceptances is LATENCY+2 cycles.
- Back-to-back: a requester holding req=1 through RESP gets a new transaction accepted at the first IDLE edge. The requester must drop req in the ack cycle to avoid a repeat.
- busy = (state != IDLE); it is Moore-decoded from state.
- Reset asserted mid-transaction (WAIT or RESP before commit edge): the transaction is abandoned, no write occurs, and ack is not produced.
- Read-after-write to the same word returns the new data, because the write completes before the read is accepted.
- Only the word address bits are used; addr[1:0] is used only for the alignment check.

Test Plan:
- Reset: drive rst=0 mid-run -> ack=0, err=0, busy=0, rdata=0x00000000 immediately, without waiting for a clock edge.
- LATENCY=2, write 0x12345678 to 0x010:
  - ack high exactly in the cycle after edge E2, err=0, busy high for 3 cycles.
  - Then read 0x010 -> rdata=0x12345678 with ack.
- Misaligned write 0xDEADBEEF to 0x013 -> ack with err=1; a later read of 0x010 still returns 0x12345678.
- Out-of-range read of 0x200 (ADDR_WIDTH=7) -> ack with err=1, rdata unchanged; read of 0x1FC -> err=0.
- Reset during WAIT:
  - Setup: word 0x020 = 0xAAAA5555; start a write of 0x0 to 0x020; pulse rst=0 in WAIT.
  - Expect: no ack, state IDLE, and a subsequent read of 0x020 returns 0xAAAA5555.
- req held high, with wdata changed during WAIT:
  - Two transactions run; acks are exactly LATENCY+2 cycles apart.
  - The stored value is the wdata sampled at acceptance.
- Run with LATENCY=0 -> ack in the cycle after acceptance.
